// File: rtl/pe_output_drain.sv
// PE array output drain: captures full result vectors into a
// 2-entry buffer and serializes them into a memory write stream.
module pe_output_drain #(
  parameter int N_PE   = 8,
  parameter int WID    = 16,
  parameter int ADDR_W = 16,
  parameter int NV_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [NV_W-1:0]              num_vec,
  input  logic [$clog2(N_PE+1)-1:0]    active_pe,
  input  logic                         cap_valid,
  output logic                         cap_ready,
  input  logic [WID*N_PE-1:0]          output_bus1_PEA,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [WID-1:0]               wr_data,
  output logic                         wr_last,
  output logic                         busy,
  output logic                         done
);

  localparam int AP_W = $clog2(N_PE+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NV_W-1:0]     nv_q, nv_d;
  logic [AP_W-1:0]     act_q, act_d;
  logic [AP_W-1:0]     lane_q, lane_d;
  logic [NV_W-1:0]     vcap_q, vcap_d;
  logic [NV_W-1:0]     vdrn_q, vdrn_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                hd_q, hd_d;
  logic                tl_q, tl_d;
  logic [WID*N_PE-1:0] buf_q [2];

  logic [AP_W-1:0]     act_eff;
  logic [WID*N_PE-1:0] head_vec;
  logic [WID-1:0]      lane_word;
  logic                cap_fire;
  logic                wr_fire;
  logic                lane_end;
  logic                vec_last;
  logic                pop;

  assign act_eff = (active_pe == '0 || active_pe > AP_W'(N_PE))
                 ? AP_W'(N_PE) : active_pe;

  assign cap_ready = (state_q == S_RUN) && (cnt_q < 2'd2)
                  && (vcap_q < nv_q);
  assign wr_valid  = (state_q == S_RUN) && (cnt_q != 2'd0);

  assign cap_fire = cap_valid && cap_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign lane_end = (lane_q == act_q - 1'b1);
  assign vec_last = (vdrn_q == nv_q - 1'b1);
  assign pop      = wr_fire && lane_end;

  assign head_vec = buf_q[hd_q];

  // select the current lane of the head vector
  always_comb begin
    lane_word = '0;
    for (int i = 0; i < N_PE; i++) begin
      if (lane_q == AP_W'(i)) begin
        lane_word = head_vec[i*WID +: WID];
      end
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = wr_valid ? lane_word : '0;
  assign wr_last = wr_valid && lane_end && vec_last;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

  // next-state for FSM, counters and buffer pointers
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    nv_d    = nv_q;
    act_d   = act_q;
    lane_d  = lane_q;
    vcap_d  = vcap_q;
    vdrn_d  = vdrn_q;
    cnt_d   = cnt_q;
    hd_d    = hd_q;
    tl_d    = tl_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          nv_d    = num_vec;
          act_d   = act_eff;
          lane_d  = '0;
          vcap_d  = '0;
          vdrn_d  = '0;
          cnt_d   = '0;
          hd_d    = 1'b0;
          tl_d    = 1'b0;
          state_d = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cap_fire) begin
          tl_d   = ~tl_q;
          vcap_d = vcap_q + 1'b1;
        end
        if (wr_fire) begin
          addr_d = addr_q + 1'b1;
          if (lane_end) begin
            lane_d = '0;
            hd_d   = ~hd_q;
            vdrn_d = vdrn_q + 1'b1;
            if (vec_last) begin
              state_d = S_DONE;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
        unique case ({cap_fire, pop})
          2'b10:   cnt_d = cnt_q + 2'd1;
          2'b01:   cnt_d = cnt_q - 2'd1;
          default: cnt_d = cnt_q;
        endcase
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      nv_q    <= '0;
      act_q   <= '0;
      lane_q  <= '0;
      vcap_q  <= '0;
      vdrn_q  <= '0;
      cnt_q   <= '0;
      hd_q    <= 1'b0;
      tl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      nv_q    <= nv_d;
      act_q   <= act_d;
      lane_q  <= lane_d;
      vcap_q  <= vcap_d;
      vdrn_q  <= vdrn_d;
      cnt_q   <= cnt_d;
      hd_q    <= hd_d;
      tl_q    <= tl_d;
    end
  end

  // vector buffer: capture the whole bus into the tail entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (cap_fire) begin
      buf_q[tl_q] <= output_bus1_PEA;
    end
  end

endmodule

// File: tb/tb_pe_output_drain.sv
// Bench for pe_output_drain: randomized jobs vs a queue-based
// reference model, plus literal checks for the directed cases.
module tb_pe_output_drain;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  num_vec = '0;
  logic [3:0]   active_pe = '0;
  logic         cap_valid = 1'b0;
  logic         cap_ready;
  logic [127:0] bus = '0;
  logic         wr_valid;
  logic         wr_ready = 1'b0;
  logic [15:0]  wr_addr;
  logic [15:0]  wr_data;
  logic         wr_last;
  logic         busy;
  logic         done;

  pe_output_drain dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .num_vec         (num_vec),
    .active_pe       (active_pe),
    .cap_valid       (cap_valid),
    .cap_ready       (cap_ready),
    .output_bus1_PEA (bus),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_last         (wr_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = -1;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  // reference model: job phase, queue of buffered vectors, word index
  int           m_ph = 0;
  logic [127:0] vq [$];
  int           m_k = 0;
  int           m_cap = 0;
  int           m_nv = 0;
  int           m_act = 0;
  logic [15:0]  m_base = '0;

  function automatic int eff(input logic [3:0] a);
    return (a == 0 || a > 8) ? 8 : int'(a);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = 0;
      vq.delete();
      m_k = 0;
      m_cap = 0;
      m_nv = 0;
      m_act = 0;
      m_base = '0;
    end else begin
      if (m_ph == 0) begin
        if (start) begin
          m_base = base_addr;
          m_nv = int'(num_vec);
          m_act = eff(active_pe);
          m_k = 0;
          m_cap = 0;
          vq.delete();
          m_ph = (num_vec == 0) ? 2 : 1;
        end
      end else if (m_ph == 1) begin
        bit wv;
        bit cr;
        wv = vq.size() > 0;
        cr = vq.size() < 2 && m_cap < m_nv;
        if (wv && wr_ready) begin
          if (m_k % m_act == m_act - 1) begin
            void'(vq.pop_front());
            if (m_k == m_nv * m_act - 1) m_ph = 2;
          end
          m_k++;
        end
        if (cr && cap_valid) begin
          vq.push_back(bus);
          m_cap++;
        end
      end else begin
        m_ph = 0;
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        l;
    int          c;
  } wr_t;
  wr_t wlog [$];

  // per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    logic         ecr;
    logic         ewv;
    logic [127:0] hv;
    logic [15:0]  ea;
    int           ln;
    ecr = (m_ph == 1) && vq.size() < 2 && m_cap < m_nv;
    ewv = (m_ph == 1) && vq.size() > 0;
    chk("cap_ready", int'(cap_ready), int'(ecr));
    chk("wr_valid", int'(wr_valid), int'(ewv));
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("done", int'(done), int'(m_ph == 2));
    if (ewv) begin
      ln = m_k % m_act;
      hv = vq[0];
      ea = m_base + 16'(m_k);
      chk("wr_addr", int'(wr_addr), int'(ea));
      chk("wr_data", int'(wr_data), int'(hv[ln*16 +: 16]));
      chk("wr_last", int'(wr_last), int'(m_k == m_nv * m_act - 1));
    end else begin
      chk("wr_last_idle", int'(wr_last), 0);
    end
    if (wr_valid && wr_ready) wlog.push_back('{wr_addr, wr_data, wr_last, cyc});
    if (done) done_cyc = cyc;
  end

  function automatic logic [127:0] gen_vec(input int vm, input int v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (vm == 0) r[i*16 +: 16] = 16'(16'h1000 + i);
      else if (vm == 1) r[i*16 +: 16] = 16'(16'hA0 + 16 * v + i);
      else r[i*16 +: 16] = 16'($urandom);
    end
    return r;
  endfunction

  task automatic drive(input int vm, input int rm);
    cap_valid = (vm == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus = gen_vec(vm, m_cap);
    if (rm == 0) wr_ready = 1'b1;
    else if (rm == 1) wr_ready = ~wr_ready;
    else wr_ready = ($urandom_range(0, 2) != 0);
    base_addr = 16'($urandom);
    num_vec = 16'($urandom);
    active_pe = 4'($urandom);
    start = (rm == 2 && m_ph == 1 && $urandom_range(0, 7) == 0);
  endtask

  task automatic launch(input logic [15:0] b, input logic [15:0] nv,
                        input logic [3:0] ap, input int vm, input int rm);
    wlog.delete();
    done_cyc = -1;
    @(posedge clk);
    #1;
    drive(vm, rm);
    start = 1'b1;
    base_addr = b;
    num_vec = nv;
    active_pe = ap;
    start_cyc = cyc;
  endtask

  task automatic run_job(input logic [15:0] b, input logic [15:0] nv,
                         input logic [3:0] ap, input int vm, input int rm,
                         input int budget);
    launch(b, nv, ap, vm, rm);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
      drive(vm, rm);
    end
    start = 1'b0;
    cap_valid = 1'b0;
    chk("job_done_in_budget", int'(done_cyc >= 0), 1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_cap_ready"}, int'(cap_ready), 0);
    chk({nm, "_wr_valid"}, int'(wr_valid), 0);
    chk({nm, "_wr_addr"}, int'(wr_addr), 0);
    chk({nm, "_wr_data"}, int'(wr_data), 0);
    chk({nm, "_wr_last"}, int'(wr_last), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  task automatic check_t1(input string nm);
    chk({nm, "_count"}, wlog.size(), 8);
    for (int i = 0; i < wlog.size() && i < 8; i++) begin
      chk({nm, "_addr"}, int'(wlog[i].a), 16'h0100 + i);
      chk({nm, "_data"}, int'(wlog[i].d), 16'h1000 + i);
      chk({nm, "_last"}, int'(wlog[i].l), int'(i == 7));
    end
    if (wlog.size() > 0)
      chk({nm, "_done_cyc"}, done_cyc, wlog[wlog.size()-1].c + 1);
  endtask

  initial begin
    logic [15:0] ea;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // 1: single full vector, always ready
    run_job(16'h0100, 16'd1, 4'd8, 0, 0, 100);
    check_t1("t1");

    // 2: three vectors, ready toggling
    wr_ready = 1'b0;
    run_job(16'h0200, 16'd3, 4'd8, 1, 1, 300);
    chk("t2_count", wlog.size(), 24);
    for (int i = 0; i < wlog.size() && i < 24; i++) begin
      chk("t2_addr", int'(wlog[i].a), 16'h0200 + i);
      chk("t2_data", int'(wlog[i].d), 16'hA0 + 16 * (i / 8) + i % 8);
    end

    // 3: partial lanes
    run_job(16'h0300, 16'd2, 4'd3, 1, 0, 100);
    chk("t3_count", wlog.size(), 6);
    for (int i = 0; i < wlog.size() && i < 6; i++) begin
      chk("t3_addr", int'(wlog[i].a), 16'h0300 + i);
      chk("t3_data", int'(wlog[i].d), 16'hA0 + 16 * (i / 3) + i % 3);
    end

    // 4: address wrap
    run_job(16'hFFFE, 16'd1, 4'd4, 2, 0, 100);
    chk("t4_count", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) begin
      ea = 16'hFFFE + 16'(i);
      chk("t4_addr", int'(wlog[i].a), int'(ea));
    end
    if (wlog.size() == 4) chk("t4_addr_lit", int'(wlog[2].a), 0);

    // 5: empty job
    run_job(16'h0500, 16'd0, 4'd8, 0, 0, 20);
    chk("t5_count", wlog.size(), 0);
    chk("t5_done_cyc", done_cyc, start_cyc + 1);

    // random jobs, including active_pe of 0 and above N_PE
    for (int j = 0; j < 8; j++) begin
      run_job(16'($urandom), 16'($urandom_range(1, 4)),
              4'($urandom_range(0, 10)), 2, 2, 400);
    end

    // 6: reset during second vector drain, then rerun job 1
    launch(16'h0600, 16'd3, 4'd8, 0, 0);
    for (int n = 0; n < 100 && wlog.size() < 10; n++) begin
      @(posedge clk);
      #1;
      drive(0, 0);
      start = 1'b0;
    end
    chk("t6_reached_vec2", int'(wlog.size() >= 10), 1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    cap_valid = 1'b0;
    rst = 1'b1;
    run_job(16'h0100, 16'd1, 4'd8, 0, 0, 100);
    check_t1("t6_rerun");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
